mem_arbiter_2p: RTL

Two-port arbiter and access sequencer for the shared single-port word memory (Mem_Read / Mem_Write / Mem_Addr / M_W_Data / M_R_Data interface).
- Port 0 is the instruction-fetch side; port 1 is the load/store side.
- Grants one request at a time, round-robin.
- Holds memory strobes for a fixed number of access cycles, then returns registered read data and a one-cycle acknowledge.
- Guarantees Mem_Read and Mem_Write are never asserted together.

---
 rtl/mem_arbiter_2p_pkg.sv | 19 +
 rtl/mem_arbiter_2p_rr.sv | 28 ++
 rtl/mem_arbiter_2p.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_2p_pkg.sv
// mem_arbiter_2p_pkg
// Shared definitions for the two-port memory arbiter:
//   - state_t    : sequencer FSM states
//   - PORT_IF/LS : port indices (0 = instruction fetch, 1 = load/store)
//   - ACC_CYC_MAX: largest supported access length in cycles
package mem_arbiter_2p_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  localparam int unsigned ACC_CYC_MAX = 15;

endpackage

// File: rtl/mem_arbiter_2p_rr.sv
// rr_arbiter_2
// Combinational two-way round-robin pick.
//   req[1:0]    in  : request lines, bit i = port i
//   last_grant  in  : port granted most recently
//   grant_valid out : at least one request present
//   grant_port  out : chosen port (single requester, or the one that
//                     was not granted last when both request)
module rr_arbiter_2
  import mem_arbiter_2p_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_port
);

  always_comb begin
    grant_valid = |req;
    grant_port  = PORT_IF;
    unique case (req)
      2'b01:   grant_port = PORT_IF;
      2'b10:   grant_port = PORT_LS;
      2'b11:   grant_port = ~last_grant;
      default: grant_port = PORT_IF;
    endcase
  end

endmodule

// File: rtl/mem_arbiter_2p.sv
// mem_arbiter_2p
// Two-port arbiter and access sequencer for a shared single-port word
// memory. Port 0 is instruction fetch, port 1 is load/store. One access
// at a time, round-robin under contention; strobes are held for ACC_CYC
// cycles, then read data is registered and a one-cycle ack is issued.
// Mem_Read and Mem_Write are mutually exclusive by construction.
//   clk, rst_n                      : clock, synchronous active-low reset
//   rN_req/we/addr/wdata            : port N request and its fields
//   rN_ack, rN_rdata                : port N completion pulse, read data
//   Mem_Read, Mem_Write             : memory strobes
//   Mem_Addr, M_W_Data, M_R_Data    : memory address, write/read data
module mem_arbiter_2p
  import mem_arbiter_2p_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACC_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              Mem_Read,
  output logic              Mem_Write,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] M_W_Data,
  input  logic [DATA_W-1:0] M_R_Data
);

  if (ACC_CYC < 1 || ACC_CYC > ACC_CYC_MAX) begin : g_bad_acc_cyc
    $error("mem_arbiter_2p: ACC_CYC must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYC - 1);

  state_t            state;
  logic              last_grant;
  logic [3:0]        cnt;

  logic              grant_valid;
  logic              grant_port;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter_2 u_rr (
    .req        ({r1_req, r0_req}),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant_port (grant_port)
  );

  always_comb begin
    sel_we    = r0_we;
    sel_addr  = r0_addr;
    sel_wdata = r0_wdata;
    if (grant_port == PORT_LS) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end
  end

  // last_grant doubles as "port currently being served" once in ACCESS,
  // and Mem_Read doubles as the read/write flag of the access in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= PORT_LS;
      cnt        <= '0;
      Mem_Read   <= 1'b0;
      Mem_Write  <= 1'b0;
      Mem_Addr   <= '0;
      M_W_Data   <= '0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_rdata   <= '0;
      r1_rdata   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_valid) begin
            Mem_Addr   <= sel_addr;
            M_W_Data   <= sel_wdata;
            Mem_Read   <= ~sel_we;
            Mem_Write  <= sel_we;
            cnt        <= CNT_INIT;
            last_grant <= grant_port;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (Mem_Read) begin
              if (last_grant == PORT_LS) r1_rdata <= M_R_Data;
              else                       r0_rdata <= M_R_Data;
            end
            Mem_Read  <= 1'b0;
            Mem_Write <= 1'b0;
            if (last_grant == PORT_LS) r1_ack <= 1'b1;
            else                       r0_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
